// File: rtl/block_sync.sv
// 64b/66b block synchronizer: hunts for a stable 2-bit sync header offset and then holds it.
// Optional BLOCK_SYNC_SLIP_WAIT_EN: ignore the first qualifying check after every slip.
module block_sync #(
    parameter int NUM_OFFSETS = 66,
    parameter int LOCK_CNT    = 32,
    parameter int WINDOW      = 64,
    parameter int ERR_LIMIT   = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         buffer_dv,
    input  logic [193:0] gbox_buffer,
    input  logic [5:0]   gbox_cnt,
    output logic [6:0]   block_offset
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int WIN_W  = $clog2(WINDOW + 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state_q;
    logic [6:0]         offset_q;
    logic [GOOD_W-1:0]  good_cnt_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic [WIN_W-1:0]   win_cnt_q;

    logic               check;
    logic [1:0]         hdr;
    logic               hdr_valid;
    logic [6:0]         offset_d;
    logic [ERR_W-1:0]   err_cnt_d;
    logic [WIN_W-1:0]   win_cnt_d;
    logic               unused_low_bits;

    // Headers only ever come from bits 193..127; the rest of the buffer is the payload.
    assign unused_low_bits = ^gbox_buffer[126:0];

    assign check = buffer_dv && (gbox_cnt <= 6'd32);

    always_comb begin
        hdr = 2'b00;
        for (int k = 0; k < NUM_OFFSETS; k++) begin
            if (offset_q == 7'(k)) begin
                hdr = gbox_buffer[193-k -: 2];
            end
        end
    end

    assign hdr_valid = hdr[1] ^ hdr[0];

    always_comb begin
        offset_d  = (offset_q == 7'(NUM_OFFSETS - 1)) ? 7'd0 : offset_q + 7'd1;
        err_cnt_d = err_cnt_q + ERR_W'(!hdr_valid);
        win_cnt_d = win_cnt_q + WIN_W'(1);
    end

`ifdef BLOCK_SYNC_SLIP_WAIT_EN
    logic settle_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            offset_q   <= 7'd0;
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
            win_cnt_q  <= '0;
`ifdef BLOCK_SYNC_SLIP_WAIT_EN
            settle_q   <= 1'b0;
`endif
        end else if (check) begin
`ifdef BLOCK_SYNC_SLIP_WAIT_EN
            if (settle_q) begin
                settle_q <= 1'b0;
            end else begin
`else
            begin
`endif
                case (state_q)
                    HUNT: begin
                        if (hdr_valid) begin
                            if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_q    <= LOCK;
                                good_cnt_q <= '0;
                                err_cnt_q  <= '0;
                                win_cnt_q  <= '0;
                            end else begin
                                good_cnt_q <= good_cnt_q + GOOD_W'(1);
                            end
                        end else begin
                            offset_q   <= offset_d;
                            good_cnt_q <= '0;
`ifdef BLOCK_SYNC_SLIP_WAIT_EN
                            settle_q   <= 1'b1;
`endif
                        end
                    end
                    LOCK: begin
                        // Error limit wins over window rollover on the same check.
                        if (err_cnt_d == ERR_W'(ERR_LIMIT)) begin
                            state_q    <= HUNT;
                            offset_q   <= offset_d;
                            good_cnt_q <= '0;
                            err_cnt_q  <= '0;
                            win_cnt_q  <= '0;
`ifdef BLOCK_SYNC_SLIP_WAIT_EN
                            settle_q   <= 1'b1;
`endif
                        end else if (win_cnt_d == WIN_W'(WINDOW)) begin
                            err_cnt_q <= '0;
                            win_cnt_q <= '0;
                        end else begin
                            err_cnt_q <= err_cnt_d;
                            win_cnt_q <= win_cnt_d;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign block_offset = offset_q;

endmodule

// File: tb/tb_block_sync.sv
// Directed bench for block_sync; lock is observed as invalid headers no longer slipping the offset.
module tb_block_sync;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         buffer_dv;
    logic [193:0] gbox_buffer;
    logic [5:0]   gbox_cnt;
    logic [6:0]   block_offset;

    int n_assert = 0;
    int n_fail   = 0;

    block_sync dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .buffer_dv    (buffer_dv),
        .gbox_buffer  (gbox_buffer),
        .gbox_cnt     (gbox_cnt),
        .block_offset (block_offset)
    );

    always #5 clk_i = ~clk_i;

    // n back-to-back checks with the given gearbox phase
    task automatic pulses(input int n, input logic [5:0] cnt);
        @(negedge clk_i);
        buffer_dv = 1'b1;
        gbox_cnt  = cnt;
        repeat (n) @(negedge clk_i);
        buffer_dv = 1'b0;
        gbox_cnt  = 6'd0;
    endtask

    task automatic set_buf(input int bitpos);
        gbox_buffer = '0;
        if (bitpos >= 0) gbox_buffer[bitpos] = 1'b1;
    endtask

    task automatic do_reset(input logic dv);
        @(negedge clk_i);
        rst_i     = 1'b1;
        buffer_dv = dv;
        @(negedge clk_i);
        rst_i     = 1'b0;
        buffer_dv = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        n_assert++;
        assert (block_offset === exp)
        else begin
            n_fail++;
            $error("FAIL %s: block_offset=%0d expected=%0d", tag, block_offset, exp);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        buffer_dv   = 1'b0;
        gbox_buffer = '0;
        gbox_cnt    = 6'd0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("reset", 7'd0);

        // Header 10 at k=0: no slips, lock after the 32nd check
        set_buf(193);
        pulses(31, 6'd0);
        chk("k0_hunt31", 7'd0);
        pulses(1, 6'd0);
        chk("k0_lock32", 7'd0);

        // Locked at k=0, bit moved to 150: 7 invalid hold, 8th forces hunt and one slip
        set_buf(150);
        pulses(1, 6'd0);
        chk("lock_hold1", 7'd0);
        pulses(6, 6'd0);
        chk("lock_hold7", 7'd0);
        pulses(1, 6'd0);
        chk("lock_lost8", 7'd1);
        pulses(40, 6'd0);
        chk("hunt_to41", 7'd41);
        pulses(1, 6'd0);
        chk("hunt_to42", 7'd42);
        pulses(32, 6'd0);
        chk("k42_lock", 7'd42);

        // Window rollover clears err_cnt: 7 bad, 57 good, 7 bad keeps lock
        set_buf(-1);
        pulses(7, 6'd0);
        chk("win_err7", 7'd42);
        set_buf(150);
        pulses(57, 6'd0);
        set_buf(-1);
        pulses(7, 6'd0);
        chk("win_rollover", 7'd42);
        pulses(1, 6'd0);
        chk("win_err8_lost", 7'd43);

        // k=43 (bits 150:149=10) locks; error limit and window end on the same check -> lose lock
        set_buf(150);
        pulses(32, 6'd0);
        chk("k43_lock", 7'd43);
        pulses(56, 6'd0);
        set_buf(-1);
        pulses(7, 6'd0);
        chk("k43_err7_win63", 7'd43);
        pulses(1, 6'd0);
        chk("err_before_window", 7'd44);

        // Reset overrides a simultaneous check with an invalid header
        do_reset(1'b1);
        chk("reset_mid_hunt", 7'd0);

        // Only bit 129: slips to k=63 then locks there
        set_buf(129);
        pulses(62, 6'd0);
        chk("b129_62", 7'd62);
        pulses(1, 6'd0);
        chk("b129_63", 7'd63);
        pulses(31, 6'd0);
        chk("b129_hunt31", 7'd63);
        pulses(1, 6'd0);
        set_buf(-1);
        pulses(1, 6'd0);
        chk("b129_locked", 7'd63);

        // Only bit 126: never valid, wraps 65->0
        do_reset(1'b0);
        set_buf(126);
        pulses(65, 6'd0);
        chk("b126_65", 7'd65);
        pulses(1, 6'd0);
        chk("b126_wrap", 7'd0);
        pulses(3, 6'd40);
        chk("gbox_cnt40", 7'd0);
        pulses(2, 6'd33);
        chk("gbox_cnt33", 7'd0);
        pulses(1, 6'd32);
        chk("gbox_cnt32", 7'd1);
        repeat (3) @(negedge clk_i);
        chk("idle_hold", 7'd1);
        pulses(10, 6'd5);
        chk("b126_11", 7'd11);
        do_reset(1'b1);
        chk("reset_again", 7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
